// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - cpu_op encodings (OP_LB .. OP_SW)
//   - FSM state encoding and access-size enum
//   - helpers: is_store, op_size, is_aligned
// ---------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_FAULT  = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  function automatic logic is_store(input logic [2:0] op);
    logic res;
    res = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    return res;
  endfunction

  function automatic lsu_size_e op_size(input logic [2:0] op);
    lsu_size_e sz;
    case (op)
      OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
      default:              sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  // Bytes are always aligned; halfwords need an even address; words need addr[1:0]=0.
  function automatic logic is_aligned(input logic [2:0] op, input logic [1:0] lane);
    logic ok;
    case (op_size(op))
      SZ_HALF: ok = ~lane[0];
      SZ_WORD: ok = (lane == 2'b00);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// ---------------------------------------------------------------------------
// lsu_if
// Bundles the CPU-side request/response signals and the DataMemory port.
//   master : view of the load/store unit (takes CPU requests, drives memory)
//   slave  : view of the environment (pipeline + DataMemory)
// ---------------------------------------------------------------------------
interface lsu_if;
  // CPU / MEM-stage side
  logic        cpu_req;
  logic [2:0]  cpu_op;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_busy;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic        cpu_misaligned;
  logic        cpu_timeout;
  // DataMemory side
  logic [31:0] address;
  logic [3:0]  mem_write;
  logic        mem_read;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        mem_ready;

  modport master (
    input  cpu_req, cpu_op, cpu_addr, cpu_wdata, read_data, mem_ready,
    output cpu_busy, cpu_done, cpu_rdata, cpu_misaligned, cpu_timeout,
           address, mem_write, mem_read, write_data
  );

  modport slave (
    output cpu_req, cpu_op, cpu_addr, cpu_wdata, read_data, mem_ready,
    input  cpu_busy, cpu_done, cpu_rdata, cpu_misaligned, cpu_timeout,
           address, mem_write, mem_read, write_data
  );
endinterface

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational lane logic for the load/store unit.
//   Store side: i_st_op/i_st_lane/i_st_wdata -> o_st_be (byte enables), o_st_wdata
//               (data replicated into every lane so the enables pick the right one).
//   Load side : i_ld_op/i_ld_lane/i_ld_rdata -> o_ld_data (extracted, extended).
// ---------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_st_op,
  input  logic [1:0]  i_st_lane,
  input  logic [31:0] i_st_wdata,
  output logic [3:0]  o_st_be,
  output logic [31:0] o_st_wdata,
  input  logic [2:0]  i_ld_op,
  input  logic [1:0]  i_ld_lane,
  input  logic [31:0] i_ld_rdata,
  output logic [31:0] o_ld_data
);

  logic [31:0] w_shifted;

  // Store enables and lane replication; loads leave the write bus quiet.
  always_comb begin
    o_st_be    = 4'b0000;
    o_st_wdata = 32'h0;
    case (i_st_op)
      OP_SB: begin
        o_st_be    = 4'b0001 << i_st_lane;
        o_st_wdata = {4{i_st_wdata[7:0]}};
      end
      OP_SH: begin
        o_st_be    = 4'b0011 << i_st_lane;
        o_st_wdata = {2{i_st_wdata[15:0]}};
      end
      OP_SW: begin
        o_st_be    = 4'hF;
        o_st_wdata = i_st_wdata;
      end
      default: ;
    endcase
  end

  // Bring the addressed lane down to bit 0 before extending.
  assign w_shifted = i_ld_rdata >> {i_ld_lane, 3'b000};

  always_comb begin
    o_ld_data = i_ld_rdata;
    case (i_ld_op)
      OP_LB:   o_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      OP_LBU:  o_ld_data = {24'h0, w_shifted[7:0]};
      OP_LH:   o_ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      OP_LHU:  o_ld_data = {16'h0, w_shifted[15:0]};
      default: o_ld_data = i_ld_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Initiator side of the CPU/DataMemory port. Accepts one load/store from the
// MEM stage, drives a registered memory access, waits for mem_ready and
// returns extended load data, flagging misaligned accesses and timeouts.
// Ports:
//   clk, rst : clock (rising edge) and asynchronous active-high reset
//   bus      : lsu_if.master - cpu_* request/response and DataMemory port
// Parameters:
//   TIMEOUT_CYCLES : cycles allowed in ACCESS without mem_ready (>=1)
//   CNT_W          : wait counter width, must hold TIMEOUT_CYCLES
// ---------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic  clk,
  input  logic  rst,
  lsu_if.master bus
);

  lsu_state_e       r_state, w_state_nxt;
  logic [2:0]       r_op, w_op_nxt;
  logic [1:0]       r_lane, w_lane_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]      r_address, w_address_nxt;
  logic [3:0]       r_mem_write, w_mem_write_nxt;
  logic             r_mem_read, w_mem_read_nxt;
  logic [31:0]      r_write_data, w_write_data_nxt;
  logic [31:0]      r_rdata, w_rdata_nxt;
  logic             r_misaligned, w_misaligned_nxt;
  logic             r_timeout, w_timeout_nxt;

  logic [3:0]       w_st_be;
  logic [31:0]      w_st_wdata;
  logic [31:0]      w_ld_data;

  // Store side looks at the live request; load side at the latched op/lane.
  lsu_align u_align (
    .i_st_op    (bus.cpu_op),
    .i_st_lane  (bus.cpu_addr[1:0]),
    .i_st_wdata (bus.cpu_wdata),
    .o_st_be    (w_st_be),
    .o_st_wdata (w_st_wdata),
    .i_ld_op    (r_op),
    .i_ld_lane  (r_lane),
    .i_ld_rdata (bus.read_data),
    .o_ld_data  (w_ld_data)
  );

  // Next-state and next-output logic. Flags default to 0 so they only last
  // for the single FAULT cycle; everything else holds unless changed.
  always_comb begin
    w_state_nxt      = r_state;
    w_op_nxt         = r_op;
    w_lane_nxt       = r_lane;
    w_cnt_nxt        = r_cnt;
    w_address_nxt    = r_address;
    w_mem_write_nxt  = r_mem_write;
    w_mem_read_nxt   = r_mem_read;
    w_write_data_nxt = r_write_data;
    w_rdata_nxt      = r_rdata;
    w_misaligned_nxt = 1'b0;
    w_timeout_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.cpu_req) begin
          if (is_aligned(bus.cpu_op, bus.cpu_addr[1:0])) begin
            w_state_nxt      = ST_ACCESS;
            w_op_nxt         = bus.cpu_op;
            w_lane_nxt       = bus.cpu_addr[1:0];
            w_cnt_nxt        = '0;
            w_address_nxt    = {2'b00, bus.cpu_addr[31:2]};
            w_mem_write_nxt  = w_st_be;
            w_mem_read_nxt   = ~is_store(bus.cpu_op);
            w_write_data_nxt = w_st_wdata;
          end else begin
            // Misaligned requests never reach the memory.
            w_state_nxt      = ST_FAULT;
            w_misaligned_nxt = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        // mem_ready is checked first so it wins over a same-cycle timeout.
        if (bus.mem_ready) begin
          w_mem_write_nxt = 4'b0000;
          w_mem_read_nxt  = 1'b0;
          if (!is_store(r_op)) w_rdata_nxt = w_ld_data;
          w_state_nxt     = ST_DONE;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_mem_write_nxt = 4'b0000;
          w_mem_read_nxt  = 1'b0;
          w_timeout_nxt   = 1'b1;
          w_state_nxt     = ST_FAULT;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      ST_FAULT: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // All state and outputs are registered; reset clears them immediately,
  // abandoning any in-flight access without a completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_op         <= OP_LB;
      r_lane       <= 2'b00;
      r_cnt        <= '0;
      r_address    <= 32'h0;
      r_mem_write  <= 4'b0000;
      r_mem_read   <= 1'b0;
      r_write_data <= 32'h0;
      r_rdata      <= 32'h0;
      r_misaligned <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_op         <= w_op_nxt;
      r_lane       <= w_lane_nxt;
      r_cnt        <= w_cnt_nxt;
      r_address    <= w_address_nxt;
      r_mem_write  <= w_mem_write_nxt;
      r_mem_read   <= w_mem_read_nxt;
      r_write_data <= w_write_data_nxt;
      r_rdata      <= w_rdata_nxt;
      r_misaligned <= w_misaligned_nxt;
      r_timeout    <= w_timeout_nxt;
    end
  end

  assign bus.cpu_busy       = (r_state != ST_IDLE);
  assign bus.cpu_done       = (r_state == ST_DONE) || (r_state == ST_FAULT);
  assign bus.cpu_rdata      = r_rdata;
  assign bus.cpu_misaligned = r_misaligned;
  assign bus.cpu_timeout    = r_timeout;
  assign bus.address        = r_address;
  assign bus.mem_write      = r_mem_write;
  assign bus.mem_read       = r_mem_read;
  assign bus.write_data     = r_write_data;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Scoreboard bench: the stimulus pushes expected memory transactions and CPU
// responses into queues computed by a word-array reference model; a memory
// responder and a completion monitor pop and compare independently.
// ---------------------------------------------------------------------------
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int NEVER   = 99;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  lsu_if bus ();

  load_store_unit #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        misaligned;
    logic        timeout;
    int          doneCycle;
  } resp_t;

  typedef struct {
    logic [31:0] address;
    logic [3:0]  be;
    logic        rd;
    logic [31:0] wdata;
    logic        isStore;
    int          waitCycles;
  } memx_t;

  resp_t       respQ[$];
  memx_t       memQ[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] refMem[16];
  logic [31:0] refRdata;
  logic [31:0] devMem[16];
  bit          devInit = 0;
  int          accCycles = 0;
  memx_t       cur;
  bit          curValid = 0;

  function automatic logic [31:0] memInit(input int i);
    return 32'h9E3779B9 * (i + 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  // DataMemory model: checks the bus every access cycle, answers after the
  // wait count chosen by the stimulus, and applies byte-enabled writes.
  always @(negedge clk) begin
    if (rst) begin
      bus.mem_ready = 1'b0;
      bus.read_data = 32'h0;
      accCycles     = 0;
      curValid      = 0;
      if (!devInit) begin
        for (int i = 0; i < 16; i++) devMem[i] = memInit(i);
        devInit = 1;
      end
    end else if (bus.mem_read || (bus.mem_write != 4'b0000)) begin
      if (accCycles == 0) begin
        if (memQ.size() == 0) begin
          checks++;
          errors++;
          curValid = 0;
          $display("[TB] FAIL unexpectedAccess: address=0x%08h mem_write=%b mem_read=%b required no access",
                   bus.address, bus.mem_write, bus.mem_read);
        end else begin
          cur      = memQ.pop_front();
          curValid = 1;
        end
      end
      if (curValid) begin
        checkOutput("address", bus.address, cur.address);
        checkOutput("memWrite", {28'h0, bus.mem_write}, {28'h0, cur.be});
        checkOutput("memRead", {31'h0, bus.mem_read}, {31'h0, cur.rd});
        if (cur.isStore) checkOutput("writeData", bus.write_data, cur.wdata);
      end
      bus.read_data = devMem[bus.address[3:0]];
      if (curValid && accCycles == cur.waitCycles) begin
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++)
          if (bus.mem_write[i]) devMem[bus.address[3:0]][8*i +: 8] = bus.write_data[8*i +: 8];
      end else begin
        bus.mem_ready = 1'b0;
      end
      accCycles++;
    end else begin
      bus.mem_ready = 1'b0;
      accCycles     = 0;
    end
  end

  // Completion monitor: every cpu_done must match the oldest expected response.
  always @(negedge clk) begin
    if (!rst && bus.cpu_done) begin
      if (respQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedDone: cpu_done=1 required 0 at cycle %0d", cyc);
      end else begin
        resp_t r;
        r = respQ.pop_front();
        checkOutput("cpuRdata", bus.cpu_rdata, r.rdata);
        checkOutput("cpuMisaligned", {31'h0, bus.cpu_misaligned}, {31'h0, r.misaligned});
        checkOutput("cpuTimeout", {31'h0, bus.cpu_timeout}, {31'h0, r.timeout});
        checkOutput("doneCycle", cyc, r.doneCycle);
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Busy"}, {31'h0, bus.cpu_busy}, 32'h0);
    checkOutput({tag, "Done"}, {31'h0, bus.cpu_done}, 32'h0);
    checkOutput({tag, "Rdata"}, bus.cpu_rdata, 32'h0);
    checkOutput({tag, "Misaligned"}, {31'h0, bus.cpu_misaligned}, 32'h0);
    checkOutput({tag, "Timeout"}, {31'h0, bus.cpu_timeout}, 32'h0);
    checkOutput({tag, "Address"}, bus.address, 32'h0);
    checkOutput({tag, "MemWrite"}, {28'h0, bus.mem_write}, 32'h0);
    checkOutput({tag, "MemRead"}, {31'h0, bus.mem_read}, 32'h0);
    checkOutput({tag, "WriteData"}, bus.write_data, 32'h0);
  endtask

  task automatic waitIdle(output bit ok);
    int budget;
    budget = 0;
    @(negedge clk);
    while (bus.cpu_busy && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    ok = !bus.cpu_busy;
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL idleWait: cpu_busy=1 required 0 after 100 cycles");
    end
  endtask

  // Issues one request and queues the expected outcome from the word-array model.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                               input int waitCycles, input bit holdReq);
    resp_t       r;
    memx_t       m;
    int          lane, sz, idx, budget;
    bit          ok, st;
    logic [31:0] word, part;
    waitIdle(ok);
    if (!ok) return;
    lane = int'(addr[1:0]);
    idx  = int'(addr[5:2]);
    sz   = (op == OP_LB || op == OP_LBU || op == OP_SB) ? 1 :
           (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : 4;
    st   = (op == OP_SB || op == OP_SH || op == OP_SW);
    bus.cpu_req   = 1'b1;
    bus.cpu_op    = op;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    r.rdata       = refRdata;
    r.misaligned  = 1'b0;
    r.timeout     = 1'b0;
    if ((lane % sz) != 0) begin
      r.misaligned = 1'b1;
      r.doneCycle  = cyc + 1;
    end else begin
      m.address    = addr >> 2;
      m.isStore    = st;
      m.rd         = !st;
      m.waitCycles = waitCycles;
      m.be         = 4'b0000;
      m.wdata      = 32'h0;
      if (sz == 1 && st) begin
        m.be    = 4'(1 << lane);
        m.wdata = {4{wdata[7:0]}};
      end else if (sz == 2 && st) begin
        m.be    = 4'(3 << lane);
        m.wdata = {2{wdata[15:0]}};
      end else if (st) begin
        m.be    = 4'hF;
        m.wdata = wdata;
      end
      if (waitCycles >= TIMEOUT) begin
        r.timeout   = 1'b1;
        r.doneCycle = cyc + 1 + TIMEOUT;
      end else begin
        r.doneCycle = cyc + 2 + waitCycles;
        word = refMem[idx];
        if (st) begin
          for (int b = 0; b < sz; b++) word[8*(lane+b) +: 8] = wdata[8*b +: 8];
          refMem[idx] = word;
        end else begin
          part = word >> (8 * lane);
          if (op == OP_LB)       refRdata = part[7]  ? (part | 32'hFFFFFF00) : (part & 32'hFF);
          else if (op == OP_LBU) refRdata = part & 32'hFF;
          else if (op == OP_LH)  refRdata = part[15] ? (part | 32'hFFFF0000) : (part & 32'hFFFF);
          else if (op == OP_LHU) refRdata = part & 32'hFFFF;
          else                   refRdata = word;
          r.rdata = refRdata;
        end
      end
      memQ.push_back(m);
    end
    respQ.push_back(r);
    @(negedge clk);
    checkOutput("busyAfterReq", {31'h0, bus.cpu_busy}, 32'h1);
    if (holdReq) begin
      budget = 0;
      while (!bus.cpu_done && budget < 100) begin
        @(negedge clk);
        budget++;
      end
    end
    bus.cpu_req = 1'b0;
    waitIdle(ok);
  endtask

  task automatic resetMidAccess();
    memx_t m;
    bit    ok;
    waitIdle(ok);
    if (!ok) return;
    m.address    = 32'h2;
    m.be         = 4'b0000;
    m.rd         = 1'b1;
    m.wdata      = 32'h0;
    m.isStore    = 1'b0;
    m.waitCycles = 10;
    memQ.push_back(m);
    bus.cpu_req  = 1'b1;
    bus.cpu_op   = OP_LW;
    bus.cpu_addr = 32'h8;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("readBeforeReset", {31'h0, bus.mem_read}, 32'h1);
    #2 rst = 1'b1;
    #1 checkAllZero("midReset");
    @(negedge clk);
    #2 rst = 1'b0;
    memQ.delete();
    refRdata = 32'h0;
  endtask

  initial begin
    bit ok;
    int rsel, w;
    bus.cpu_req   = 1'b0;
    bus.cpu_op    = OP_LB;
    bus.cpu_addr  = 32'h0;
    bus.cpu_wdata = 32'h0;
    for (int i = 0; i < 16; i++) refMem[i] = memInit(i);
    refRdata = 32'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    #2 rst = 1'b0;

    $display("[TB] directed stores");
    applyStimulus(OP_SW, 32'h10, 32'hDEADBEEF, 0, 0);
    applyStimulus(OP_SB, 32'h13, 32'h000000A5, 0, 0);
    applyStimulus(OP_SH, 32'h12, 32'h00001234, 1, 0);

    $display("[TB] directed loads");
    applyStimulus(OP_SW, 32'h0, 32'h80FF7F01, 0, 0);
    applyStimulus(OP_LB, 32'h1, 32'h0, 0, 0);
    applyStimulus(OP_LB, 32'h2, 32'h0, 2, 0);
    applyStimulus(OP_LBU, 32'h3, 32'h0, 0, 0);
    applyStimulus(OP_LH, 32'h2, 32'h0, 1, 0);
    applyStimulus(OP_LHU, 32'h0, 32'h0, 0, 0);
    applyStimulus(OP_LW, 32'h10, 32'h0, 3, 0);

    $display("[TB] misaligned and timeout");
    applyStimulus(OP_LW, 32'h6, 32'h0, 0, 0);
    applyStimulus(OP_LH, 32'h1, 32'h0, 0, 0);
    applyStimulus(OP_SW, 32'h2, 32'h11111111, 0, 0);
    applyStimulus(OP_LW, 32'h8, 32'h0, NEVER, 0);
    applyStimulus(OP_SW, 32'hC, 32'h22222222, NEVER, 0);
    applyStimulus(OP_LW, 32'h8, 32'h0, TIMEOUT - 1, 0);

    $display("[TB] reset during access");
    resetMidAccess();
    applyStimulus(OP_SW, 32'h20, 32'hCAFEF00D, 3, 0);
    applyStimulus(OP_LW, 32'h20, 32'h0, 1, 1);
    repeat (3) @(negedge clk);
    applyStimulus(OP_LBU, 32'h21, 32'h0, 0, 0);

    $display("[TB] random traffic");
    for (int n = 0; n < 60; n++) begin
      rsel = $urandom_range(0, 19);
      w    = (rsel < 15) ? (rsel % 4) : (rsel < 18) ? (TIMEOUT - 1) : NEVER;
      applyStimulus(3'($urandom_range(0, 7)), 32'($urandom_range(0, 63)), $urandom, w, n[2]);
    end

    waitIdle(ok);
    repeat (4) @(negedge clk);
    checkOutput("respQueueEmpty", 32'(respQ.size()), 32'h0);
    checkOutput("memQueueEmpty", 32'(memQ.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
